// File: rtl/opc_bus_pkg.sv
// Shared definitions for the CPU-to-external-memory bus multiplexer:
// sequencer states, control-pin bit positions and the default read timeout.
package opc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_STB  = 3'd3,
        ST_WR_HOLD = 3'd4,
        ST_ACK     = 3'd5
    } bus_state_t;

    // Bit positions inside uo_out; bits [2:0] carry address[10:8], bit 7 is tied low.
    localparam int UO_ALE  = 3;
    localparam int UO_RD   = 4;
    localparam int UO_WR   = 5;
    localparam int UO_BUSY = 6;

    // Number of RD_WAIT cycles tolerated before a read is forced to complete.
    localparam int DEFAULT_TIMEOUT = 15;

    // Assembles the control-pin byte so every state builds uo_out the same way.
    function automatic logic [7:0] ctrl_pins(
        input logic [2:0] addr_hi,
        input logic       ale,
        input logic       rd,
        input logic       wr,
        input logic       busy
    );
        logic [7:0] pins;
        pins           = 8'h00;
        pins[2:0]      = addr_hi;
        pins[UO_ALE]   = ale;
        pins[UO_RD]    = rd;
        pins[UO_WR]    = wr;
        pins[UO_BUSY]  = busy;
        return pins;
    endfunction

endpackage

// File: rtl/opc_bus_if.sv
// CPU-side request/acknowledge bus between a bus master and the multiplexer.
interface opc_bus_if;

    logic        req;
    logic [10:0] addr;
    logic        rnw;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    logic        timeout;

    modport master (
        output req, addr, rnw, wdata,
        input  rdata, ack, timeout
    );

    modport slave (
        input  req, addr, rnw, wdata,
        output rdata, ack, timeout
    );

endinterface

// File: rtl/opc_bus_timer.sv
// Read-wait counter: counts cycles while enabled and flags the last allowed
// cycle so the sequencer can force a read completion.
module opc_bus_timer
    import opc_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The counter never needs to exceed TIMEOUT-1.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_r;

    // Expiry is raised during the TIMEOUT-th enabled cycle.
    always_comb begin
        expired = enable && (count_r == LAST);
    end

    // Wait counter: cleared outside the wait phase, saturates at the last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && !expired) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/opc_bus_mux.sv
// Multiplexes an 11-bit CPU address/data bus onto an 8-bit shared pad bus
// with ALE/RD/WR strobes. Address low byte and data share uio; the high
// address bits sit on uo_out[2:0]. All pins are registered.
module opc_bus_mux
    import opc_bus_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    opc_bus_if.slave    cpu,
    input  logic        mem_rdy,
    output logic [7:0]  uo_out,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);

    bus_state_t  state_r;
    logic [10:0] addr_r;
    logic        rnw_r;
    logic [7:0]  wdata_r;
    logic [7:0]  rdata_r;
    logic        ack_r;
    logic        timeout_r;
    logic [7:0]  uo_r;
    logic [7:0]  uio_out_r;
    logic [7:0]  uio_oe_r;

    logic        wait_en;
    logic        wait_clr;
    logic        wait_expired;

    assign wait_en  = (state_r == ST_RD_WAIT);
    assign wait_clr = (state_r != ST_RD_WAIT);

    opc_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clr),
        .enable  (wait_en),
        .expired (wait_expired)
    );

    assign uo_out      = uo_r;
    assign uio_out     = uio_out_r;
    assign uio_oe      = uio_oe_r;
    assign cpu.rdata   = rdata_r;
    assign cpu.ack     = ack_r;
    assign cpu.timeout = timeout_r;

    // Bus sequencer: advances the transaction and registers every pin for the coming cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= 11'h000;
            rnw_r     <= 1'b0;
            wdata_r   <= 8'h00;
            rdata_r   <= 8'h00;
            ack_r     <= 1'b0;
            timeout_r <= 1'b0;
            uo_r      <= 8'h00;
            uio_out_r <= 8'h00;
            uio_oe_r  <= 8'h00;
        end else begin
            ack_r     <= 1'b0;
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cpu.req) begin
                        // Capture the whole request; the CPU may change its lines afterwards.
                        addr_r    <= cpu.addr;
                        rnw_r     <= cpu.rnw;
                        wdata_r   <= cpu.wdata;
                        state_r   <= ST_ADDR;
                        uo_r      <= ctrl_pins(cpu.addr[10:8], 1'b1, 1'b0, 1'b0, 1'b1);
                        uio_out_r <= cpu.addr[7:0];
                        uio_oe_r  <= 8'hFF;
                    end else begin
                        state_r   <= ST_IDLE;
                        uo_r      <= 8'h00;
                        uio_out_r <= 8'h00;
                        uio_oe_r  <= 8'h00;
                    end
                end
                ST_ADDR: begin
                    if (rnw_r) begin
                        // Release the pads before the memory starts driving them.
                        state_r   <= ST_RD_WAIT;
                        uo_r      <= ctrl_pins(addr_r[10:8], 1'b0, 1'b1, 1'b0, 1'b1);
                        uio_out_r <= 8'h00;
                        uio_oe_r  <= 8'h00;
                    end else begin
                        state_r   <= ST_WR_STB;
                        uo_r      <= ctrl_pins(addr_r[10:8], 1'b0, 1'b0, 1'b1, 1'b1);
                        uio_out_r <= wdata_r;
                        uio_oe_r  <= 8'hFF;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rdy) begin
                        // A ready memory wins over a simultaneous timeout.
                        rdata_r   <= uio_in;
                        ack_r     <= 1'b1;
                        state_r   <= ST_ACK;
                        uo_r      <= ctrl_pins(addr_r[10:8], 1'b0, 1'b0, 1'b0, 1'b1);
                        uio_out_r <= 8'h00;
                        uio_oe_r  <= 8'h00;
                    end else if (wait_expired) begin
                        rdata_r   <= 8'hFF;
                        timeout_r <= 1'b1;
                        ack_r     <= 1'b1;
                        state_r   <= ST_ACK;
                        uo_r      <= ctrl_pins(addr_r[10:8], 1'b0, 1'b0, 1'b0, 1'b1);
                        uio_out_r <= 8'h00;
                        uio_oe_r  <= 8'h00;
                    end else begin
                        state_r   <= ST_RD_WAIT;
                    end
                end
                ST_WR_STB: begin
                    // Drop WR but keep the data on the pads for one hold cycle.
                    state_r   <= ST_WR_HOLD;
                    uo_r      <= ctrl_pins(addr_r[10:8], 1'b0, 1'b0, 1'b0, 1'b1);
                    uio_out_r <= wdata_r;
                    uio_oe_r  <= 8'hFF;
                end
                ST_WR_HOLD: begin
                    ack_r     <= 1'b1;
                    state_r   <= ST_ACK;
                    uo_r      <= ctrl_pins(addr_r[10:8], 1'b0, 1'b0, 1'b0, 1'b1);
                    uio_out_r <= 8'h00;
                    uio_oe_r  <= 8'h00;
                end
                ST_ACK: begin
                    // Always pass through IDLE so a held request waits one cycle.
                    state_r   <= ST_IDLE;
                    uo_r      <= 8'h00;
                    uio_out_r <= 8'h00;
                    uio_oe_r  <= 8'h00;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    uo_r      <= 8'h00;
                    uio_out_r <= 8'h00;
                    uio_oe_r  <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opc_bus_mux.sv
// Bench for opc_bus_mux: directed scenarios plus randomized transactions,
// checked every cycle against a transaction-level expectation queue.
module tb_opc_bus_mux;

    localparam int TMO = 15;
    localparam logic [7:0] P_ALE  = 8'h08;
    localparam logic [7:0] P_RD   = 8'h10;
    localparam logic [7:0] P_WR   = 8'h20;
    localparam logic [7:0] P_BUSY = 8'h40;

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] uout;
        logic [7:0] oe;
        logic       ack;
        logic       to;
        logic [7:0] rdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_rdy;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    opc_bus_if bus ();

    opc_bus_mux #(.TIMEOUT(TMO)) dut (
        .clk     (clk),
        .rst     (rst),
        .cpu     (bus.slave),
        .mem_rdy (mem_rdy),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    vec_t exp_q[$];
    logic [7:0] last_rdata;
    int last_ack_t;

    int cyc = 0;
    int ale_cyc = 0;
    int ack_cyc = 0;
    int ack_count = 0;
    int obs_lat = 0;
    int obs_rd_cycles = 0;
    int obs_wr_cycles = 0;
    int obs_gap = 0;
    logic [7:0] obs_ale_uio, obs_rdata, obs_wr_uio, obs_wr_oe, obs_hold_uio, obs_hold_oe;
    logic [2:0] obs_ale_hi;
    logic       obs_to;
    logic       prev_wr = 1'b0;
    vec_t       cmp_e, cmp_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t idle_vec(input logic [7:0] rd);
        vec_t v;
        v = '{uo: 8'h00, uout: 8'h00, oe: 8'h00, ack: 1'b0, to: 1'b0, rdata: rd};
        return v;
    endfunction

    // Expected pins for cycle t of a transaction (t=1 is the address phase).
    function automatic vec_t exp_at(input int t, input logic rnw, input logic [10:0] a,
                                    input logic [7:0] wd, input logic [7:0] rd,
                                    input int ack_t, input bit to, input logic [7:0] prev_rd);
        vec_t v;
        logic [7:0] hi;
        hi = {5'b00000, a[10:8]};
        v = idle_vec(prev_rd);
        if (t == 1) begin
            v.uo = hi | P_ALE | P_BUSY; v.uout = a[7:0]; v.oe = 8'hFF;
        end else if (t == ack_t) begin
            v.uo = hi | P_BUSY; v.ack = 1'b1; v.to = to;
            if (rnw) v.rdata = to ? 8'hFF : rd;
        end else if (rnw) begin
            v.uo = hi | P_RD | P_BUSY;
        end else if (t == 2) begin
            v.uo = hi | P_WR | P_BUSY; v.uout = wd; v.oe = 8'hFF;
        end else begin
            v.uo = hi | P_BUSY; v.uout = wd; v.oe = 8'hFF;
        end
        return v;
    endfunction

    task automatic idle_step();
        bus.req = 1'b0;
        mem_rdy = 1'($urandom_range(0, 1));
        uio_in  = 8'($urandom);
        step();
        exp_q.push_back(idle_vec(last_rdata));
    endtask

    // One transaction; mem_rdy first rises on wait cycle rdy_at (0 = already high).
    task automatic do_txn(input logic rnw, input logic [10:0] a, input logic [7:0] wd,
                          input logic [7:0] rd, input int rdy_at, input bit drop,
                          input int abort_at);
        int   r;
        int   ack_t;
        bit   to;
        logic rdy;
        vec_t v;
        r = (rdy_at < 1) ? 1 : rdy_at;
        if (!rnw) begin
            to = 1'b0; ack_t = 4;
        end else if (r <= TMO) begin
            to = 1'b0; ack_t = r + 2;
        end else begin
            to = 1'b1; ack_t = TMO + 2;
        end
        last_ack_t = ack_t;
        v = idle_vec(last_rdata);
        for (int t = 1; t <= ack_t; t++) begin
            if (t == 1) begin
                bus.req = 1'b1; bus.addr = a; bus.rnw = rnw; bus.wdata = wd;
                rdy = (rdy_at == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                bus.req   = drop ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.addr  = 11'($urandom);
                bus.rnw   = 1'($urandom_range(0, 1));
                bus.wdata = 8'($urandom);
                if (rnw && t >= 3) rdy = ((t - 2) >= rdy_at);
                else rdy = 1'($urandom_range(0, 1));
            end
            mem_rdy = rdy;
            uio_in  = rdy ? rd : 8'($urandom);
            if (t == abort_at) begin
                rst = 1'b1; bus.req = 1'b0;
                step();
                last_rdata = 8'h00;
                exp_q.push_back(idle_vec(8'h00));
                rst = 1'b0;
                step();
                exp_q.push_back(idle_vec(8'h00));
                return;
            end
            step();
            v = exp_at(t, rnw, a, wd, rd, ack_t, to, last_rdata);
            exp_q.push_back(v);
        end
        last_rdata = v.rdata;
        // Request still high during ACK with unrelated lines: must not be taken.
        bus.req = 1'b1; bus.addr = 11'($urandom); bus.rnw = 1'($urandom_range(0, 1));
        mem_rdy = 1'($urandom_range(0, 1)); uio_in = 8'($urandom);
        step();
        exp_q.push_back(idle_vec(last_rdata));
        bus.req = 1'b0;
    endtask

    // Per-cycle compare against the expectation queue, plus pin invariants and observations.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            cmp_e = exp_q.pop_front();
            cmp_a = {uo_out, uio_out, uio_oe, bus.ack, bus.timeout, bus.rdata};
            check("cycle_pins", cmp_a, cmp_e);
            check("rd_wr_exclusive", uo_out[4] & uo_out[5], 1'b0);
            check("oe_all_or_none", (uio_oe == 8'h00) || (uio_oe == 8'hFF), 1'b1);
            check("oe_off_during_rd", uo_out[4] & (uio_oe != 8'h00), 1'b0);
        end
        if (uo_out[3] === 1'b1) begin
            obs_gap = cyc - ack_cyc; ale_cyc = cyc;
            obs_ale_uio = uio_out; obs_ale_hi = uo_out[2:0];
            obs_rd_cycles = 0; obs_wr_cycles = 0;
        end
        if (uo_out[4] === 1'b1) obs_rd_cycles++;
        if (prev_wr) begin
            obs_hold_uio = uio_out; obs_hold_oe = uio_oe;
        end
        prev_wr = (uo_out[5] === 1'b1);
        if (prev_wr) begin
            obs_wr_cycles++; obs_wr_uio = uio_out; obs_wr_oe = uio_oe;
        end
        if (bus.ack === 1'b1) begin
            ack_count++; ack_cyc = cyc; obs_lat = cyc - ale_cyc + 1;
            obs_rdata = bus.rdata; obs_to = bus.timeout;
        end
    end

    initial begin
        int acks_before;
        int gap;
        int ab;
        rst = 1'b1; bus.req = 1'b0; bus.addr = 11'h000; bus.rnw = 1'b0; bus.wdata = 8'h00;
        mem_rdy = 1'b0; uio_in = 8'h00; last_rdata = 8'h00;
        step(); exp_q.push_back(idle_vec(8'h00));
        step(); exp_q.push_back(idle_vec(8'h00));
        rst = 1'b0;
        idle_step();

        // Read with memory already ready.
        do_txn(1'b1, 11'h5A3, 8'h00, 8'h3C, 0, 1'b0, 0);
        check("model_read_ack_t", last_ack_t, 3);
        check("read_ale_uio", obs_ale_uio, 8'hA3);
        check("read_ale_hi", obs_ale_hi, 3'b101);
        check("read_latency", obs_lat, 3);
        check("read_rdata", obs_rdata, 8'h3C);
        check("read_no_timeout", obs_to, 1'b0);
        idle_step();

        // Write strobe and hold.
        do_txn(1'b0, 11'h100, 8'hC9, 8'h00, 0, 1'b0, 0);
        check("model_write_ack_t", last_ack_t, 4);
        check("write_wr_cycles", obs_wr_cycles, 1);
        check("write_wr_data", obs_wr_uio, 8'hC9);
        check("write_wr_oe", obs_wr_oe, 8'hFF);
        check("write_hold_data", obs_hold_uio, 8'hC9);
        check("write_hold_oe", obs_hold_oe, 8'hFF);
        check("write_latency", obs_lat, 4);
        idle_step();

        // Read that never sees mem_rdy.
        do_txn(1'b1, 11'h7FF, 8'h00, 8'h55, 99, 1'b0, 0);
        check("timeout_rdata", obs_rdata, 8'hFF);
        check("timeout_flag", obs_to, 1'b1);
        check("timeout_wait_cycles", obs_rd_cycles, TMO);
        idle_step();

        // mem_rdy arriving on the last allowed wait cycle wins.
        do_txn(1'b1, 11'h0F0, 8'h00, 8'h11, TMO, 1'b0, 0);
        check("late_rdy_rdata", obs_rdata, 8'h11);
        check("late_rdy_no_timeout", obs_to, 1'b0);
        check("late_rdy_wait_cycles", obs_rd_cycles, TMO);
        idle_step();

        // Reset during RD_WAIT, then during WR_STB: no acknowledge may appear.
        acks_before = ack_count;
        do_txn(1'b1, 11'h321, 8'h00, 8'h77, 99, 1'b0, 3);
        do_txn(1'b0, 11'h456, 8'hAB, 8'h00, 0, 1'b0, 3);
        idle_step();
        check("no_ack_after_reset", ack_count, acks_before);
        do_txn(1'b1, 11'h2AA, 8'h00, 8'h5E, 2, 1'b1, 0);
        check("read_after_reset", obs_rdata, 8'h5E);
        check("read_after_reset_lat", obs_lat, 4);

        // Write then read with the request held: exactly one IDLE cycle between.
        do_txn(1'b0, 11'h2F0, 8'h96, 8'h00, 0, 1'b0, 0);
        do_txn(1'b1, 11'h10F, 8'h00, 8'hE1, 0, 1'b0, 0);
        check("b2b_gap", obs_gap, 2);
        check("b2b_rdata", obs_rdata, 8'hE1);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_step();
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 4)) : 0;
            do_txn(1'($urandom_range(0, 1)), 11'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, TMO + 3)), ($urandom_range(0, 3) == 0), ab);
        end

        idle_step();
        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/opc_bus_mux.md
OPC_BUS_MUX -- requirements
Module: opc_bus_mux

Interface
REQ-001 Parameter TIMEOUT, default 15, meaning the maximum number of RD_WAIT cycles before a forced read completion.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU bus request; held until cpu_ack.
REQ-005 cpu_addr  input  11  CPU address.
REQ-006 cpu_rnw  input  1  1=read, 0=write.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_rdata  output  8  read data; valid in the cpu_ack cycle.
REQ-009 cpu_ack  output  1  one-cycle completion pulse.
REQ-010 cpu_timeout  output  1  pulses with cpu_ack when a read timed out.
REQ-011 mem_rdy  input  1  external memory ready (board wiring: ui_in[7]).
REQ-012 uo_out  output  8  control pins: [2:0] address[10:8], [3] ALE, [4] RD, [5] WR, [6] BUSY, [7] constant 0.
REQ-013 uio_in  input  8  bidirectional pad input path.
REQ-014 uio_out  output  8  bidirectional pad output path.
REQ-015 uio_oe  output  8  pad enables, all-ones or all-zeros only.

Function
REQ-016 States SHALL be IDLE, ADDR, RD_WAIT, WR_STB, WR_HOLD, ACK.
REQ-017 IDLE with cpu_req=1 SHALL capture addr/rnw/wdata into internal registers and go to ADDR; later input changes are ignored until ACK.
REQ-018 ADDR: uio_oe=8'hFF, uio_out=addr[7:0], ALE=1, BUSY=1; one cycle, then RD_WAIT if read, else WR_STB.
REQ-019 RD_WAIT: uio_oe=0, RD=1; when mem_rdy=1, capture uio_in into cpu_rdata and go to ACK.
REQ-020 RD_WAIT SHALL count cycles; on the TIMEOUT-th cycle without mem_rdy, set cpu_rdata=8'hFF, flag a timeout, and go to ACK.
REQ-021 mem_rdy and timeout in the same cycle: mem_rdy wins, with no timeout flag.
REQ-022 WR_STB: uio_oe=8'hFF, uio_out=wdata, WR=1; one cycle, then WR_HOLD.
REQ-023 WR_HOLD: data still driven, WR=0; one cycle, then ACK.
REQ-024 ACK: cpu_ack=1 for exactly one cycle, uio_oe=0, and cpu_timeout set if flagged; then IDLE.
REQ-025 Latency, counting the accept edge as 0:
  - read with mem_rdy already high: ack 3 cycles after accept;
  - write: ack 4 cycles after accept.
REQ-026 uo_out[2:0] SHALL hold the captured addr[10:8] from ADDR through ACK, and 0 in IDLE.
REQ-027 RD and WR SHALL never be high together.
REQ-028 uio_oe SHALL be 0 for at least one cycle between a read data phase and any later ADDR phase (the ACK cycle provides this).
REQ-029 cpu_req dropped mid-transaction: the transaction SHALL still complete and ack.
REQ-030 cpu_req high in the ACK cycle SHALL NOT be accepted until the next cycle in IDLE; back-to-back minimum is one IDLE cycle.
REQ-031 cpu_rdata SHALL retain its last value outside ACK.

Reset
REQ-032 rst=1 SHALL, at the next edge and from any state, force:
  - state=IDLE;
  - uo_out=0, uio_out=0, uio_oe=0;
  - cpu_ack=0, cpu_timeout=0, cpu_rdata=0;
  - timeout counter=0.
REQ-033 A transaction interrupted by reset SHALL NOT produce cpu_ack.

Structure
REQ-034 Package opc_bus_pkg SHALL hold:
  - the state encoding;
  - the uo_out bit-index constants (ALE, RD, WR, BUSY);
  - the default TIMEOUT.
REQ-035 One sub-module, opc_bus_timer, SHALL hold the RD_WAIT wait counter, with clear, enable and expired ports; everything else is flat.

Verification
REQ-036 Read, mem_rdy tied 1, addr=11'h5A3, uio_in=8'h3C -> ALE cycle with uio_out=8'hA3 and uo_out[2:0]=3'b101; cpu_ack 3 cycles after accept; cpu_rdata=8'h3C.
REQ-037 Write, addr=11'h100, wdata=8'hC9 -> WR high for 1 cycle with uio_out=8'hC9 and uio_oe=8'hFF; data held 1 more cycle; ack at accept+4.
REQ-038 Read, mem_rdy held 0 -> cpu_ack with cpu_rdata=8'hFF and cpu_timeout=1, after exactly TIMEOUT RD_WAIT cycles.
REQ-039 Read, mem_rdy rises on the TIMEOUT-th cycle with uio_in=8'h11 -> cpu_rdata=8'h11 and cpu_timeout=0.
REQ-040 rst pulsed during RD_WAIT, then during WR_STB -> next cycle all outputs 0, no cpu_ack, and a following read completes normally.
REQ-041 Write then read back-to-back, cpu_req held high -> one IDLE cycle between them, uio_oe never high during RD, RD and WR never both high.
